// File: rtl/fpu_pkg.sv
// Shared floating-point types and defaults for the fmul/fadd/fdiv issue blocks.
package fpu_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } float32_t;

   localparam int FMUL_LATENCY_DEFAULT = 2;
   localparam int TAG_W_DEFAULT        = 4;

   typedef struct packed {
      float32_t                 op1;
      float32_t                 op2;
      logic [TAG_W_DEFAULT-1:0] tag;
   } fmul_req_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO with occupancy output; head is read combinationally.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fpu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && (count != (AW+1)'(DEPTH));
   assign do_pop   = pop && (count != '0);
   assign pop_data = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fmul_issue.sv
// Valid/ready issue front end for the fixed-latency fmul pipeline.
// Operands are registered toward fmul, a valid/tag shift register tracks the
// pipeline, and results land in an output FIFO. Issue is credit-limited so the
// FIFO can never overflow. Optional perf counters: FMUL_ISSUE_PERF_EN.
module fmul_issue
   import fpu_pkg::*;
#(
   parameter int LATENCY = FMUL_LATENCY_DEFAULT,
   parameter int TAG_W   = TAG_W_DEFAULT,
   parameter int DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_op1,
   input  logic [31:0]       in_op2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [31:0]       fmul_op1,
   output logic [31:0]       fmul_op2,
   input  logic [31:0]       fmul_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic [TAG_W-1:0]  out_tag
`ifdef FMUL_ISSUE_PERF_EN
   ,
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   float32_t           op_a;
   float32_t           op_b;
   logic [LATENCY-1:0] pipe_v;
   logic [TAG_W-1:0]   pipe_tag [LATENCY];
   logic [CW-1:0]      inflight;
   logic [CW-1:0]      occ;
   logic [CW:0]        credit_used;
   logic               accept;
   logic               pop;
   logic [31+TAG_W:0]  head;

   assign fmul_op1 = op_a;
   assign fmul_op2 = op_b;

   // Count ops currently inside the fmul pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(pipe_v[i]);
   end

   // Credit uses only registered state, so in_ready has no path from in_valid/out_ready.
   assign credit_used = {1'b0, inflight} + {1'b0, occ};
   assign in_ready    = !reset && (credit_used < (CW+1)'(DEPTH));
   assign accept      = in_valid && in_ready;

   // Operand registers feeding fmul; held when nothing is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a <= '0;
         op_b <= '0;
      end else if (accept) begin
         op_a <= in_op1;
         op_b <= in_op2;
      end
   end

   // Valid/tag shadow of the fmul pipeline; advances every cycle, never stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
      end else begin
         pipe_v[0]   <= accept;
         pipe_tag[0] <= accept ? in_tag : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   assign out_valid  = (occ != '0);
   assign pop        = out_valid && out_ready;
   assign out_result = head[TAG_W +: 32];
   assign out_tag    = head[TAG_W-1:0];

   fpu_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32 + TAG_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pipe_v[LATENCY-1]),
      .push_data ({fmul_result, pipe_tag[LATENCY-1]}),
      .pop       (pop),
      .pop_data  (head),
      .count     (occ)
   );

`ifdef FMUL_ISSUE_PERF_EN
   // Issue and stall event counters; wrap at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (accept)                 perf_issued <= perf_issued + 32'd1;
         if (in_valid && !in_ready)  perf_stall  <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fmul_issue.sv
// Directed self-checking bench for fmul_issue with a LATENCY=2 fmul model.
module tb_fmul_issue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_op1;
   logic [31:0] in_op2;
   logic [3:0]  in_tag;
   logic [31:0] fmul_op1;
   logic [31:0] fmul_op2;
   logic [31:0] fmul_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_tag;
`ifdef FMUL_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] ONE = 32'h3F80_0000;

   fmul_issue #(.LATENCY(2), .TAG_W(4), .DEPTH(4)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op1      (in_op1),
      .in_op2      (in_op2),
      .in_tag      (in_tag),
      .fmul_op1    (fmul_op1),
      .fmul_op2    (fmul_op2),
      .fmul_result (fmul_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag)
`ifdef FMUL_ISSUE_PERF_EN
      ,
      .perf_issued (perf_issued),
      .perf_stall  (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tabulated products for the directed operands; anything else gets a scrambled value.
   function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
      if (a == ONE) return b;
      if (b == ONE) return a;
      if ((a == 32'h3FC0_0000 && b == 32'h4000_0000) ||
          (a == 32'h4000_0000 && b == 32'h3FC0_0000)) return 32'h4040_0000;
      return a ^ b ^ 32'hDEAD_0000;
   endfunction

   // fmul with LATENCY=2: one internal register after the operand registers.
   logic [31:0] fmul_stage;
   always @(posedge clk) fmul_stage <= fmul_model(fmul_op1, fmul_op2);
   assign fmul_result = fmul_stage;

   // Push into a full FIFO must be unreachable.
   always @(posedge clk) begin
      if (!reset && u_dut.u_fifo.push && (u_dut.u_fifo.count == 3'd4)) begin
         n_fail++;
         $error("FAIL fifo_overflow: observed push with count %0d required no push", u_dut.u_fifo.count);
      end
   end

   function automatic logic [31:0] val(input int i);
      return 32'h40A0_0000 | (32'(i) << 8);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input int t);
      in_valid = v;
      in_op1   = a;
      in_op2   = b;
      in_tag   = 4'(t);
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 0);
      step(); step(); step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fmul_op1", fmul_op1, 32'h0);
      check("rst_fmul_op2", fmul_op2, 32'h0);
      reset = 1'b0;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);
      step();
      check("rel_out_valid", 32'(out_valid), 32'd0);

      // Single op: 1.5 * 2.0 = 3.0, tag 3.
      drive(1'b1, 32'h3FC0_0000, 32'h4000_0000, 3);
      step();
      drive(1'b0, 32'h0, 32'h0, 0);
      check("single_op1_reg", fmul_op1, 32'h3FC0_0000);
      check("single_op2_reg", fmul_op2, 32'h4000_0000);
      step();
      check("single_ov_early", 32'(out_valid), 32'd0);
      step();
      check("single_ov", 32'(out_valid), 32'd1);
      check("single_result", out_result, 32'h4040_0000);
      check("single_tag", 32'(out_tag), 32'd3);
      step();
      check("single_hold_ov", 32'(out_valid), 32'd1);
      check("single_hold_res", out_result, 32'h4040_0000);
      out_ready = 1'b1;
      step();
      check("single_popped", 32'(out_valid), 32'd0);

      // Back-to-back: 8 ops, consumer always ready.
      for (int k = 0; k <= 10; k++) begin
         drive(k < 8, ONE, val(k), k);
         if (k < 8) check("b2b_in_ready", 32'(in_ready), 32'd1);
         step();
         check("b2b_out_valid", 32'(out_valid), 32'((k >= 2) && (k <= 9)));
         if ((k >= 2) && (k <= 9)) begin
            check("b2b_tag", 32'(out_tag), 32'(k - 2));
            check("b2b_result", out_result, val(k - 2));
         end
      end
      drive(1'b0, 32'h0, 32'h0, 0);

      // Backpressure: consumer stalled, requester always valid.
      reset = 1'b1;
      out_ready = 1'b0;
      step();
      reset = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, ONE, val(i), i);
         check("bp_in_ready", 32'(in_ready), 32'(i < 4));
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 0);
      check("bp_count", 32'(u_dut.u_fifo.count), 32'd4);
`ifdef FMUL_ISSUE_PERF_EN
      check("perf_issued", perf_issued, 32'd4);
      check("perf_stall", perf_stall, 32'd4);
`endif
      out_ready = 1'b1;
      #1;
      for (int j = 0; j < 4; j++) begin
         check("drain_ov", 32'(out_valid), 32'd1);
         check("drain_tag", 32'(out_tag), 32'(j));
         check("drain_result", out_result, val(j));
         check("drain_in_ready", 32'(in_ready), 32'(j > 0));
         step();
      end
      check("drain_empty", 32'(out_valid), 32'd0);

      // Simultaneous push and pop with three entries buffered.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ONE, val(8 + i), 8 + i);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 0);
      step(); step();
      check("sim_count3", 32'(u_dut.u_fifo.count), 32'd3);
      check("sim_in_ready", 32'(in_ready), 32'd1);
      check("sim_head", 32'(out_tag), 32'd8);
      drive(1'b1, ONE, val(11), 11);
      step();
      drive(1'b0, 32'h0, 32'h0, 0);
      check("sim_no_credit", 32'(in_ready), 32'd0);
      step();
      out_ready = 1'b1;
      step();
      check("sim_count_hold", 32'(u_dut.u_fifo.count), 32'd3);
      for (int t = 9; t <= 11; t++) begin
         check("sim_ov", 32'(out_valid), 32'd1);
         check("sim_tag", 32'(out_tag), 32'(t));
         check("sim_result", out_result, val(t));
         step();
      end
      check("sim_empty", 32'(out_valid), 32'd0);

      // Reset with two ops in flight and two buffered.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ONE, val(i), 12 + i);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 0);
      check("mid_count2", 32'(u_dut.u_fifo.count), 32'd2);
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      step();
      reset = 1'b0;
      #1;
      check("mid_rel_ov", 32'(out_valid), 32'd0);
      check("mid_rel_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("mid_no_stale", 32'(out_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
